register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write, two-read CPU register file.
- Adds configurable read-port count, a second write port, write-through bypass, hardwired zero register and a post-reset clear sequencer with a ready flag.
- Sits in the decode stage of the single-cycle datapath; also usable by a future pipelined core.

Parameters:
- N, 32, data width in bits.
- address_size, 5, address width; depth = 2**address_size entries.
- NUM_READ, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- write_0  input  1  write enable, port 0.
- wr_addr_0  input  address_size  write address, port 0.
- wr_data_0  input  N  write data, port 0.
- write_1  input  1  write enable, port 1.
- wr_addr_1  input  address_size  write address, port 1.
- wr_data_1  input  N  write data, port 1.
- rd_addr  input  NUM_READ*address_size  packed read addresses; port i at bits [i*address_size +: address_size].
- rd_data  output  NUM_READ*N  packed read data; port i at bits [i*N +: N].
- ready  output  1  high once clear sequence is complete.

Behaviour:
- Storage: 2**address_size x N array; no initial-file load. Contents are defined only by the clear sequence and by writes.
- FSM states: CLEAR and RUN.
  - reset=0 at a clk edge: state<=CLEAR, clear pointer<=0, ready<=0.
  - CLEAR: each cycle writes 0 to entry[ptr] and increments ptr. On the cycle ptr = depth-1 is written, go to RUN and set ready<=1 (ready rises depth cycles after reset deasserts).
  - RUN: normal operation; stays until next reset.
  - Reset mid-CLEAR restarts from ptr=0.
- Writes, RUN only:
  - On posedge clk, entry[wr_addr_k] <= wr_data_k for each asserted write_k.
  - Same address on both ports: port 1 wins; port 0 is dropped.
  - Address 0 with ZERO_REG=1: write ignored.
  - write_0/write_1 in CLEAR: ignored, no buffering.
- Reads, combinational, zero latency:
  - rd_data[i] = 0 if ZERO_REG=1 and rd_addr[i]=0.
  - Else if ready and write_1 and wr_addr_1==rd_addr[i]: wr_data_1.
  - Else if ready and write_0 and wr_addr_0==rd_addr[i]: wr_data_0.
  - Else entry[rd_addr[i]].
  - Bypass means a same-cycle read returns the value being written.
  - In CLEAR, rd_data = 0 for all ports regardless of array contents.
- Reset values: ready=0, rd_data=0, FSM=CLEAR, ptr=0.
- Address wrap: ptr is address_size+1 bits wide; compare to depth-1 with no overflow. All addresses are full-range, no out-of-range case.
- No reads or writes ever stall; ready is the only handshake. The control unit must hold writes until ready=1.

Decomposition:
- Shared package (cpu_pkg): data width 32, register address width 5, REG_ZERO index 0, FSM state encoding (CLEAR=1'b0, RUN=1'b1).
- One sub-module, regfile_read_port: the per-port bypass/zero-mux, instantiated NUM_READ times via generate.
- Array, write logic and FSM stay in the top module.

Test Plan:
- Reset low 2 cycles then high -> ready=0 for 32 cycles, ready=1 on cycle 32; all 32 entries read 0.
- RUN: write_0=1, wr_addr_0=5, wr_data_0=32'hDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=32'hDEADBEEF (bypass); next cycle with write_0=0 still 32'hDEADBEEF.
- Both ports write addr 7: port0 32'h11111111, port1 32'h22222222 -> entry 7 = 32'h22222222; same-cycle read of 7 returns 32'h22222222.
- Write addr 0 with 32'hFFFFFFFF (ZERO_REG=1) -> read of addr 0 returns 0 in that cycle and all later cycles.
- Write addr 3 = 32'h0000ABCD, then reset at ptr=10 mid-CLEAR -> ready=0, clear restarts; after 32 cycles addr 3 reads 0; writes issued during CLEAR are lost.
- NUM_READ=4, address_size=3 build: write 8 distinct values, read 4 different addresses simultaneously -> each rd_data slice matches; ready asserts 8 cycles after reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath constants for the CPU core.
// Register file widths, the zero register index and sequencer state codes.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    localparam logic STATE_CLEAR = 1'b0;
    localparam logic STATE_RUN   = 1'b1;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the multi-port register file.
// Selects zero, same-cycle write data or stored data for one address.
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int N            = DATA_W,
    parameter int address_size = REG_ADDR_W,
    parameter int ZERO_REG     = 1
) (
    input  logic                    ready,
    input  logic                    write_0,
    input  logic [address_size-1:0] wr_addr_0,
    input  logic [N-1:0]            wr_data_0,
    input  logic                    write_1,
    input  logic [address_size-1:0] wr_addr_1,
    input  logic [N-1:0]            wr_data_1,
    input  logic [address_size-1:0] rd_addr,
    input  logic [N-1:0]            entry,
    output logic [N-1:0]            rd_data
);

    logic is_zero;

    assign is_zero = (ZERO_REG != 0) &&
                     (rd_addr == address_size'(REG_ZERO));

    // Port 1 is checked first so the bypass agrees with the write priority.
    always_comb begin
        rd_data = entry;
        if (!ready || is_zero)
            rd_data = '0;
        else if (write_1 && wr_addr_1 == rd_addr)
            rd_data = wr_data_1;
        else if (write_0 && wr_addr_0 == rd_addr)
            rd_data = wr_data_0;
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with two write ports, write-through bypass
// and a post-reset clear sequencer that raises ready when done.
module register_file_mp
    import cpu_pkg::*;
#(
    parameter int N            = DATA_W,
    parameter int address_size = REG_ADDR_W,
    parameter int NUM_READ     = 2,
    parameter int ZERO_REG     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             write_0,
    input  logic [address_size-1:0]          wr_addr_0,
    input  logic [N-1:0]                     wr_data_0,
    input  logic                             write_1,
    input  logic [address_size-1:0]          wr_addr_1,
    input  logic [N-1:0]                     wr_data_1,
    input  logic [NUM_READ*address_size-1:0] rd_addr,
    output logic [NUM_READ*N-1:0]            rd_data,
    output logic                             ready
);

    localparam int DEPTH = 1 << address_size;
    localparam logic [address_size:0] LAST = (address_size + 1)'(DEPTH - 1);

    logic [N-1:0]            mem [DEPTH];
    logic                    state;
    logic [address_size:0]   ptr;
    logic                    wr_ok_0;
    logic                    wr_ok_1;

    function automatic logic writable(input logic [address_size-1:0] addr);
        return !((ZERO_REG != 0) && addr == address_size'(REG_ZERO));
    endfunction

    assign wr_ok_0 = write_0 && writable(wr_addr_0);
    assign wr_ok_1 = write_1 && writable(wr_addr_1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= STATE_CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
        end else if (state == STATE_CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST) begin
                state <= STATE_RUN;
                ready <= 1'b1;
            end
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset && state == STATE_CLEAR) begin
            mem[ptr[address_size-1:0]] <= '0;
        end else if (reset && state == STATE_RUN) begin
            if (wr_ok_0)
                mem[wr_addr_0] <= wr_data_0;
            if (wr_ok_1)
                mem[wr_addr_1] <= wr_data_1;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        regfile_read_port #(
            .N            (N),
            .address_size (address_size),
            .ZERO_REG     (ZERO_REG)
        ) u_port (
            .ready     (ready),
            .write_0   (write_0),
            .wr_addr_0 (wr_addr_0),
            .wr_data_0 (wr_data_0),
            .write_1   (write_1),
            .wr_addr_1 (wr_addr_1),
            .wr_data_1 (wr_data_1),
            .rd_addr   (rd_addr[i*address_size +: address_size]),
            .entry     (mem[rd_addr[i*address_size +: address_size]]),
            .rd_data   (rd_data[i*N +: N])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed table, corner
// sequences, random traffic against an array model, and a 4-port build.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_0, write_1;
    logic [4:0]  wr_addr_0, wr_addr_1;
    logic [31:0] wr_data_0, wr_data_1;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        ready;

    logic        reset4;
    logic        w4_0, w4_1;
    logic [2:0]  wa4_0, wa4_1;
    logic [31:0] wd4_0, wd4_1;
    logic [11:0] rd_addr4;
    logic [127:0] rd_data4;
    logic        ready4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    register_file_mp dut (
        .clk (clk), .reset (reset),
        .write_0 (write_0), .wr_addr_0 (wr_addr_0), .wr_data_0 (wr_data_0),
        .write_1 (write_1), .wr_addr_1 (wr_addr_1), .wr_data_1 (wr_data_1),
        .rd_addr (rd_addr), .rd_data (rd_data), .ready (ready)
    );

    register_file_mp #(.N(32), .address_size(3), .NUM_READ(4), .ZERO_REG(1)) dut4 (
        .clk (clk), .reset (reset4),
        .write_0 (w4_0), .wr_addr_0 (wa4_0), .wr_data_0 (wd4_0),
        .write_1 (w4_1), .wr_addr_1 (wa4_1), .wr_data_1 (wd4_1),
        .rd_addr (rd_addr4), .rd_data (rd_data4), .ready (ready4)
    );

    // Reference model: contents, ready flag and clear progress
    logic [31:0] mem_m [32];
    logic        rdy_m;
    int          cnt_m;

    typedef struct {
        logic        we0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (!rdy_m || a == 5'd0) return 32'h0;
        if (write_1 && wr_addr_1 == a) return wr_data_1;
        if (write_0 && wr_addr_0 == a) return wr_data_0;
        return mem_m[a];
    endfunction

    function automatic void model_edge();
        if (!reset) begin
            rdy_m = 1'b0;
            cnt_m = 0;
        end else if (!rdy_m) begin
            cnt_m++;
            if (cnt_m == 32) begin
                rdy_m = 1'b1;
                for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
            end
        end else begin
            if (write_0 && wr_addr_0 != 5'd0) mem_m[wr_addr_0] = wr_data_0;
            if (write_1 && wr_addr_1 != 5'd0) mem_m[wr_addr_1] = wr_data_1;
        end
    endfunction

    // Inputs are set at negedge; compare, clock, update model, back to negedge
    task automatic step();
        #1;
        chk("ready", {31'b0, ready}, {31'b0, rdy_m});
        chk("rd0", rd_data[31:0], model_read(rd_addr[4:0]));
        chk("rd1", rd_data[63:32], model_read(rd_addr[9:5]));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        write_0 = 1'b0; write_1 = 1'b0;
        wr_addr_0 = '0; wr_addr_1 = '0;
        wr_data_0 = '0; wr_data_1 = '0;
    endtask

    initial begin
        int n, n4;
        logic [31:0] vals4 [8];

        tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1, 7, 32'h11111111, 1, 7, 32'h22222222, 7, 5, 32'h22222222, 32'hDEADBEEF};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 7, 7, 32'h22222222, 32'h22222222};
        tbl[4] = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 7, 0, 32'h22222222};
        tbl[5] = '{0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF};
        tbl[7] = '{1, 3, 32'h0000ABCD, 0, 0, 0, 3, 9, 32'h0000ABCD, 0};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 3, 31, 32'h0000ABCD, 0};

        idle();
        rd_addr = '0;
        reset = 1'b0; reset4 = 1'b0;
        w4_0 = 0; w4_1 = 0; wa4_0 = '0; wa4_1 = '0; wd4_0 = '0; wd4_1 = '0;
        rd_addr4 = '0;
        rdy_m = 1'b0; cnt_m = 0;
        for (int i = 0; i < 32; i++) mem_m[i] = 'x;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_rd", rd_data[31:0] | rd_data[63:32], 32'h0);
        chk("reset_ready4", {31'b0, ready4}, 32'h0);

        reset = 1'b1; reset4 = 1'b1;
        n = 0; n4 = -1;
        while (!ready && n < 100) begin
            if (ready4 && n4 < 0) n4 = n;
            rd_addr = {5'(n + 1), 5'(n)};
            step();
            n++;
        end
        chk("ready_latency", 32'(n), 32'd32);
        chk("ready4_latency", 32'(n4), 32'd8);

        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            chk("clear_rd0", rd_data[31:0], 32'h0);
            chk("clear_rd1", rd_data[63:32], 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            write_0 = tbl[i].we0; wr_addr_0 = tbl[i].a0; wr_data_0 = tbl[i].d0;
            write_1 = tbl[i].we1; wr_addr_1 = tbl[i].a1; wr_data_1 = tbl[i].d1;
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            #1;
            chk($sformatf("tbl%0d_rd0", i), rd_data[31:0], tbl[i].e0);
            chk($sformatf("tbl%0d_rd1", i), rd_data[63:32], tbl[i].e1);
            step();
        end
        idle();

        // Reset in the middle of the clear sequence restarts it
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (10) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        write_0 = 1'b1; wr_addr_0 = 5'd3; wr_data_0 = 32'h55555555;
        write_1 = 1'b1; wr_addr_1 = 5'd4; wr_data_1 = 32'h66666666;
        rd_addr = {5'd4, 5'd3};
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        chk("restart_latency", 32'(n), 32'd32);
        idle();
        #1;
        chk("restart_addr3", rd_data[31:0], 32'h0);
        chk("restart_addr4", rd_data[63:32], 32'h0);

        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 99) != 0);
            write_0   = 1'($urandom);
            write_1   = 1'($urandom);
            wr_addr_0 = 5'($urandom);
            wr_addr_1 = ($urandom_range(0, 3) == 0) ? wr_addr_0 : 5'($urandom);
            wr_data_0 = $urandom;
            wr_data_1 = $urandom;
            rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wr_addr_1 : 5'($urandom);
            rd_addr[9:5] = ($urandom_range(0, 2) == 0) ? wr_addr_0 : 5'($urandom);
            step();
        end
        reset = 1'b1;
        idle();

        for (int i = 0; i < 8; i++) vals4[i] = 32'hA0000000 + 32'(i * 32'h01010101);
        for (int i = 0; i < 8; i += 2) begin
            w4_0 = 1'b1; wa4_0 = 3'(i);     wd4_0 = vals4[i];
            w4_1 = 1'b1; wa4_1 = 3'(i + 1); wd4_1 = vals4[i + 1];
            @(posedge clk);
            @(negedge clk);
        end
        w4_0 = 1'b0; w4_1 = 1'b0;
        rd_addr4 = {3'd7, 3'd6, 3'd2, 3'd1};
        #1;
        chk("p4_rd0", rd_data4[31:0], vals4[1]);
        chk("p4_rd1", rd_data4[63:32], vals4[2]);
        chk("p4_rd2", rd_data4[95:64], vals4[6]);
        chk("p4_rd3", rd_data4[127:96], vals4[7]);
        rd_addr4 = {3'd5, 3'd4, 3'd3, 3'd0};
        #1;
        chk("p4_rd0b", rd_data4[31:0], 32'h0);
        chk("p4_rd1b", rd_data4[63:32], vals4[3]);
        chk("p4_rd2b", rd_data4[95:64], vals4[4]);
        chk("p4_rd3b", rd_data4[127:96], vals4[5]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
